// File: rtl/vdp_io_initiator.sv
// vdp_io_initiator: host-side initiator for the V9958 VDP CPU port.
// Queued host requests become mode/cdo + csw_n/csr_n strobe sequences with
// programmable setup, strobe and hold timing. Read data is sampled from cdi.
// Optional build macro: VDP_IO_RECOVERY_EN adds a RECOV state of
// RECOVERY_CYC idle cycles after HOLD for back-to-back access spacing.
module vdp_io_initiator #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 3,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [1:0] req_port,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [1:0] mode,
  output logic       csw_n,
  output logic       csr_n,
  output logic [7:0] cdo,
  input  logic [7:0] cdi
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Phase counters load N-1 and count down to zero.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  // Elaboration-time parameter checks.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("SETUP_CYC must be in 1..15");
  end
  if (STROBE_CYC < 2 || STROBE_CYC > 15) begin : g_bad_strobe
    $error("STROBE_CYC must be in 2..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("HOLD_CYC must be in 1..15");
  end

`ifdef VDP_IO_RECOVERY_EN
  localparam logic [3:0] RECOV_LD = 4'(RECOVERY_CYC - 1);
  if (RECOVERY_CYC < 1 || RECOVERY_CYC > 15) begin : g_bad_recov
    $error("RECOVERY_CYC must be in 1..15");
  end
`else
  // RECOVERY_CYC has no effect without the recovery state.
  if (RECOVERY_CYC != 0) begin : g_recov_ignored
  end
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
`ifdef VDP_IO_RECOVERY_EN
    S_HOLD,
    S_RECOV
`else
    S_HOLD
`endif
  } state_t;

  // Request queue: entry = {wr, port[1:0], wdata[7:0]}
  logic [10:0]      fifo_mem_q [FIFO_DEPTH];
  logic [10:0]      fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_full, fifo_empty, push, pop;
  logic [10:0]      head;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       cdo_q, cdo_d;
  logic             csw_n_q, csw_n_d;
  logic             csr_n_q, csr_n_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;

  // Full is taken from the registered count, so a pop only reopens the
  // queue on the following cycle.
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign head       = fifo_mem_q[rd_ptr_q];

  // Queue pointer, occupancy and storage update.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = {req_wr, req_port, req_wdata};
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue storage holds no control state, so it is not reset.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  // Queue control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Access sequencer: next state, phase counter, bus values and response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    mode_d      = mode_q;
    cdo_d       = cdo_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          wr_d    = head[10];
          mode_d  = head[9:8];
          cdo_d   = head[10] ? head[7:0] : 8'h00;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = STROBE_LD;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
          // cdi is sampled on the same edge that releases csr_n.
          if (!wr_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = cdi;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
`ifdef VDP_IO_RECOVERY_EN
          cnt_d   = RECOV_LD;
          state_d = S_RECOV;
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef VDP_IO_RECOVERY_EN
      S_RECOV: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Strobes are registered from the next state so they are glitch-free
    // and only one of them can ever be low.
    csw_n_d = !((state_d == S_STROBE) && wr_d);
    csr_n_d = !((state_d == S_STROBE) && !wr_d);
  end

  // Sequencer and pin registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      mode_q      <= 2'd0;
      cdo_q       <= 8'h00;
      csw_n_q     <= 1'b1;
      csr_n_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      mode_q      <= mode_d;
      cdo_q       <= cdo_d;
      csw_n_q     <= csw_n_d;
      csr_n_q     <= csr_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign mode      = mode_q;
  assign cdo       = cdo_q;
  assign csw_n     = csw_n_q;
  assign csr_n     = csr_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_vdp_io_initiator.sv
// Directed bench for vdp_io_initiator. Honors VDP_IO_RECOVERY_EN when defined.
module tb_vdp_io_initiator;

  localparam int FIFO_DEPTH   = 4;
  localparam int SETUP_CYC    = 1;
  localparam int STROBE_CYC   = 3;
  localparam int HOLD_CYC     = 1;
  localparam int RECOVERY_CYC = 2;
`ifdef VDP_IO_RECOVERY_EN
  localparam int EXTRA = RECOVERY_CYC;
`else
  localparam int EXTRA = 0;
`endif
  localparam int EXP_GAP = HOLD_CYC + EXTRA + 1 + SETUP_CYC;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [1:0] req_port;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [1:0] mode;
  logic       csw_n;
  logic       csr_n;
  logic [7:0] cdo;
  logic [7:0] cdi;

  vdp_io_initiator #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SETUP_CYC   (SETUP_CYC),
    .STROBE_CYC  (STROBE_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .RECOVERY_CYC(RECOVERY_CYC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .req_port (req_port),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .mode     (mode),
    .csw_n    (csw_n),
    .csr_n    (csr_n),
    .cdo      (cdo),
    .cdi      (cdi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Strobe/response trace, sampled on the falling edge.
  int         wfall[$];
  int         wrise[$];
  logic [7:0] wdat[$];
  int         rfall[$];
  int         rrise[$];
  logic [7:0] rsp_q[$];
  int         both_low = 0;

  initial begin
    int   cyc;
    logic csw_prev;
    logic csr_prev;
    cyc = 0;
    csw_prev = 1'b1;
    csr_prev = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (csw_prev && !csw_n) begin
        wfall.push_back(cyc);
        wdat.push_back(cdo);
      end
      if (!csw_prev && csw_n) wrise.push_back(cyc);
      if (csr_prev && !csr_n) rfall.push_back(cyc);
      if (!csr_prev && csr_n) rrise.push_back(cyc);
      if (!csw_n && !csr_n) both_low++;
      if (rsp_valid) rsp_q.push_back(rsp_rdata);
      csw_prev = csw_n;
      csr_prev = csr_n;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    int nf, nr, nrd, sent, tries, first_low;
    logic ok;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_port  = 2'd0;
    req_wdata = 8'h00;
    cdi       = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csw_n", csw_n, 1'b1);
    chk("rst_csr_n", csr_n, 1'b1);
    chk("rst_mode", mode, 2'd0);
    chk("rst_cdo", cdo, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    reset_n = 1'b1;
    tick();

    // Test 1: single write, port 0, data A5
    nf = wfall.size();
    nr = rsp_q.size();
    req_valid = 1'b1; req_wr = 1'b1; req_port = 2'd0; req_wdata = 8'hA5;
    tick();                                   // E0
    req_valid = 1'b0;
    chk("t1_busy_after_push", busy, 1'b1);
    tick();                                   // E1
    chk("t1_mode", mode, 2'd0);
    chk("t1_cdo", cdo, 8'hA5);
    chk("t1_csw_setup", csw_n, 1'b1);
    tick();                                   // E2
    chk("t1_csw_low", csw_n, 1'b0);
    chk("t1_csr_high", csr_n, 1'b1);
    repeat (3) tick();                        // E5
    chk("t1_csw_released", csw_n, 1'b1);
    chk("t1_busy_hold", busy, 1'b1);
    tick();                                   // E6
    chk("t1_busy_idle", busy, (EXTRA == 0) ? 1'b0 : 1'b1);
    wait_idle(50);
    chk("t1_pulses", wfall.size() - nf, 1);
    if (wrise.size() > nf) chk("t1_len", wrise[nf] - wfall[nf], STROBE_CYC);
    chk("t1_no_rsp", rsp_q.size() - nr, 0);

    // Test 2: single read, port 1, cdi = 3C
    nr  = rsp_q.size();
    nrd = rfall.size();
    req_valid = 1'b1; req_wr = 1'b0; req_port = 2'd1; req_wdata = 8'hFF;
    tick();                                   // E0
    req_valid = 1'b0;
    tick();                                   // E1
    chk("t2_mode", mode, 2'd1);
    chk("t2_cdo_zero", cdo, 8'h00);
    tick();                                   // E2
    chk("t2_csr_low", csr_n, 1'b0);
    chk("t2_csw_high", csw_n, 1'b1);
    chk("t2_no_early_rsp", rsp_valid, 1'b0);
    repeat (3) tick();                        // E5
    chk("t2_csr_released", csr_n, 1'b1);
    chk("t2_rsp_valid", rsp_valid, 1'b1);
    chk("t2_rsp_rdata", rsp_rdata, 8'h3C);
    tick();                                   // E6
    chk("t2_rsp_pulse", rsp_valid, 1'b0);
    wait_idle(50);
    chk("t2_rsp_count", rsp_q.size() - nr, 1);
    if (rrise.size() > nrd) chk("t2_len", rrise[nrd] - rfall[nrd], STROBE_CYC);

    // Test 3: six back-to-back writes 1..6
    nf = wfall.size();
    sent = 1; tries = 0; first_low = 0;
    while (sent <= 6 && tries < 40) begin
      req_valid = 1'b1; req_wr = 1'b1; req_port = 2'd0; req_wdata = 8'(sent);
      tries++;
      ok = req_ready;
      if (!ok && first_low == 0) first_low = tries;
      tick();
      if (ok) sent++;
    end
    req_valid = 1'b0;
    chk("t3_first_not_ready", first_low, 6);
    chk("t3_all_sent", sent, 7);
    wait_idle(300);
    chk("t3_pulses", wfall.size() - nf, 6);
    for (int i = 0; i < 6; i++) begin
      if (wfall.size() > nf + i && wrise.size() > nf + i) begin
        chk($sformatf("t3_data%0d", i), wdat[nf + i], 8'(i + 1));
        chk($sformatf("t3_len%0d", i), wrise[nf + i] - wfall[nf + i], STROBE_CYC);
        if (i > 0) chk($sformatf("t3_gap%0d", i), wfall[nf + i] - wrise[nf + i - 1], EXP_GAP);
      end
    end

    // Test 6: full queue with a pop and a new request in the same cycle
    nf = wfall.size();
    req_wr = 1'b1; req_port = 2'd2;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_wdata = 8'(8'h10 + i);
      tick();
    end
    req_wdata = 8'h15;
    for (int k = 0; k < 3 + EXTRA; k++) begin
      chk($sformatf("t6_full%0d", k), req_ready, 1'b0);
      tick();
    end
    chk("t6_ready_after_pop", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    wait_idle(300);
    chk("t6_pulses", wfall.size() - nf, 6);
    for (int i = 0; i < 6; i++) begin
      if (wfall.size() > nf + i) chk($sformatf("t6_data%0d", i), wdat[nf + i], 8'(8'h10 + i));
    end
    chk("t6_mode", mode, 2'd2);

    // Test 4: reset during the second strobe cycle of a write
    nr = rsp_q.size();
    req_wr = 1'b1; req_port = 2'd0;
    req_valid = 1'b1; req_wdata = 8'h77;
    tick();                                   // E0
    req_wdata = 8'h78;
    tick();                                   // E1
    req_valid = 1'b0;
    tick();                                   // E2
    chk("t4_csw_low", csw_n, 1'b0);
    tick();                                   // E3
    #2;
    reset_n = 1'b0;
    #1;
    chk("t4_csw_async", csw_n, 1'b1);
    chk("t4_csr_async", csr_n, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_ready", req_ready, 1'b1);
    chk("t4_cdo", cdo, 8'h00);
    tick();
    reset_n = 1'b1;
    nf = wfall.size();
    repeat (12) tick();
    chk("t4_no_strobe", wfall.size() - nf, 0);
    chk("t4_no_rsp", rsp_q.size() - nr, 0);
    chk("t4_busy_after", busy, 1'b0);
    chk("t4_ready_after", req_ready, 1'b1);

    chk("never_both_low", both_low, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vdp_io_initiator.md
Name: vdp_io_initiator

Overview:
CPU-side bus initiator for the V9958 VDP I/O port. It turns queued host transactions into csw_n/csr_n/mode/cdo strobe sequences with programmable setup, strobe, hold and recovery timing. On reads it samples cdi.
Sits between a host (Z80 core, boot loader or bench) and the VDP top-level CPU pins, in the same clk domain as the VDP.

Parameters:
FIFO_DEPTH, 4, request queue depth; power of two, 2..16
SETUP_CYC, 1, cycles mode/cdo are stable before strobe assertion; 1..15
STROBE_CYC, 3, cycles the strobe is held low; 2..15 (the responder needs ≥2 clk to latch)
HOLD_CYC, 1, cycles mode/cdo are held after strobe release; 1..15
RECOVERY_CYC, 2, idle cycles after HOLD (only with VDP_IO_RECOVERY_EN); 1..15

Ports:
clk  in  1  VDP pixel-domain clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  host request valid
req_ready  out  1  queue can accept; = !fifo_full
req_wr  in  1  1 = write, 0 = read
req_port  in  2  VDP port select (drives mode)
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle pulse: read data valid
rsp_rdata  out  8  captured read data
busy  out  1  state != IDLE or FIFO non-empty
mode  out  2  VDP port select to VDP
csw_n  out  1  write strobe, active low
csr_n  out  1  read strobe, active low
cdo  out  8  write data to VDP
cdi  in  8  read data from VDP

Behaviour:
- Interface: one clock clk; reset_n asynchronous, active-low.
- Reset (async): csw_n=1, csr_n=1, mode=0, cdo=0, rsp_valid=0, rsp_rdata=0, busy=0, FIFO flushed, state=IDLE.
- Reset mid-transaction: strobes release immediately and no rsp_valid is generated. After release, req_ready=1.
- FIFO: entry {wr,port,wdata}. Push when req_valid && req_ready. Push and pop in the same cycle are legal. When full, req_ready=0 and req_valid is ignored; a pop in that cycle does not make req_ready=1 until the next cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOV.
- IDLE: if FIFO non-empty, pop, load mode/cdo (cdo=0 on reads) and go to SETUP.
- SETUP: strobes high; stay SETUP_CYC cycles; then go to STROBE.
- STROBE: csw_n=0 (write) or csr_n=0 (read); never both. Stay STROBE_CYC cycles.
  - On the edge leaving STROBE, both strobes return high. On reads, cdi is captured into rsp_rdata on that edge and rsp_valid is high for exactly the next cycle.
- HOLD: mode/cdo unchanged; stay HOLD_CYC cycles.
  - Without the macro, go to IDLE.
  - IDLE may pop the next entry in its first cycle, so the minimum gap between strobe edges is HOLD_CYC+1+SETUP_CYC cycles.
- Latency (defaults): push at edge E0; SETUP entered at E1; strobe low from E2 through E5 (3 cycles); read rsp_valid in the cycle after E5.
- mode/cdo change only on IDLE→SETUP. Both strobes are high in every state except STROBE, so the responder always sees one strobe transition per access.
- Counters are 4-bit, load N-1 and count down to 0. A parameter of 0 is illegal; elaboration asserts on it.
- busy is combinational from state and FIFO count.

Optional Feature:
Macro VDP_IO_RECOVERY_EN.
- Defined: HOLD→RECOV. RECOV keeps strobes high for RECOVERY_CYC cycles, then goes to IDLE. This meets V9938/V9958 access-spacing limits for back-to-back VRAM data port writes.
- Undefined: RECOV state and its counter are absent; HOLD→IDLE directly; RECOVERY_CYC is ignored.

Test Plan:
1. Single write, port=0, data=8'hA5, idle queue → mode=0 and cdo=A5 from E1; csw_n low exactly 3 cycles (E2–E5); csr_n stays 1; no rsp_valid; busy drops the cycle after HOLD.
2. Single read, port=1, cdi=8'h3C during the strobe → csr_n low 3 cycles; rsp_rdata=3C with a 1-cycle rsp_valid after E5; cdo=0.
3. Push 6 writes in consecutive cycles (data 1..6) → req_ready falls after 4 are queued; writes emerge in order 1..N; every csw_n pulse is 3 cycles with ≥3 high cycles between pulses (macro off).
4. Assert reset_n low during the second strobe cycle of a write → csw_n=1 asynchronously; FIFO empty; no further strobes after release; req_ready=1.
5. With VDP_IO_RECOVERY_EN and 2 queued writes → gap between csw_n rising and the next falling edge is HOLD+RECOVERY+1+SETUP = 5 cycles.
6. FIFO full with a simultaneous pop and req_valid → request not accepted that cycle; accepted next cycle; no entry lost or duplicated.
